// File: rtl/cache_request_credit_scheduler_pkg.sv
// Shared types and constants for the credit-based cache request scheduler.
// The FIFO credit count must stay equal to the request generator's FIFO_WRITE_DEPTH.
package cache_request_credit_scheduler_pkg;

    localparam int CACHE_REQUEST_FIFO_CREDITS = 16;
    localparam int CACHE_NUM_MEMORY_REQUESTOR = 2;

    typedef enum logic [1:0] {
        S_SETUP,
        S_ARB,
        S_DRAIN,
        S_DRAINED
    } cache_sched_state_t;

    // Pointer width that stays legal for a single requestor.
    function automatic int rr_ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_request_credit_scheduler_rr_select.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr wins.
// Produces a one-hot select plus an any-request flag.
module round_robin_priority_select
    import cache_request_credit_scheduler_pkg::*;
#(
    parameter int N = CACHE_NUM_MEMORY_REQUESTOR,
    localparam int PTR_W = rr_ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     sel,
    output logic             any
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = rr_ptr;
        for (int off = 0; off < N; off++) begin
            if (!found && req[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
            idx = (idx == PTR_W'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

    assign any = |req;

endmodule

// File: rtl/cache_request_credit_scheduler.sv
// Credit-based round-robin scheduler in front of the cache request generator.
// Grants only while the generator FIFO has guaranteed space; supports drain/quiesce.
module cache_request_credit_scheduler
    import cache_request_credit_scheduler_pkg::*;
#(
    parameter int NUM_MEMORY_REQUESTOR = CACHE_NUM_MEMORY_REQUESTOR,
    parameter int NUM_CREDITS          = CACHE_REQUEST_FIFO_CREDITS,
    localparam int CREDIT_W            = $clog2(NUM_CREDITS + 1)
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic [NUM_MEMORY_REQUESTOR-1:0] arbiter_request_in,
    input  logic                            fifo_setup_signal_in,
    input  logic                            credit_return_in,
    input  logic                            drain_in,
    output logic [NUM_MEMORY_REQUESTOR-1:0] arbiter_grant_out,
    output logic [CREDIT_W-1:0]             credits_out,
    output logic                            drained_out,
    output logic                            credit_overflow_out
);

    localparam int N     = NUM_MEMORY_REQUESTOR;
    localparam int PTR_W = rr_ptr_width(N);
    localparam logic [CREDIT_W-1:0] CREDITS_FULL = CREDIT_W'(NUM_CREDITS);

    cache_sched_state_t  state;
    logic [CREDIT_W-1:0] credits;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    rr_ptr_next;
    logic [N-1:0]        sel;
    logic                any_req;
    logic [CREDIT_W:0]   credits_eff;
    logic                grant_now;

    round_robin_priority_select #(
        .N(N)
    ) u_rr_select (
        .req    (arbiter_request_in),
        .rr_ptr (rr_ptr),
        .sel    (sel),
        .any    (any_req)
    );

    // A return arriving this cycle frees a slot early enough to fund a grant at zero credits.
    assign credits_eff = {1'b0, credits} + {{CREDIT_W{1'b0}}, credit_return_in};

    assign grant_now = (state == S_ARB) && any_req && (credits_eff != '0)
                       && !drain_in && !fifo_setup_signal_in;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) grant_idx = PTR_W'(i);
        end
        rr_ptr_next = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end

    // NOTE: reset is asynchronous on assertion; the registers below are the only state, no memories.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state               <= S_SETUP;
            credits             <= CREDITS_FULL;
            rr_ptr              <= '0;
            arbiter_grant_out   <= '0;
            drained_out         <= 1'b0;
            credit_overflow_out <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            arbiter_grant_out <= grant_now ? sel : '0;
            if (grant_now) rr_ptr <= rr_ptr_next;

            if (fifo_setup_signal_in) begin
                // FIFO is being reset: everything in flight is gone.
                state       <= S_SETUP;
                credits     <= CREDITS_FULL;
                drained_out <= 1'b0;
            end else begin
                case (state)
                    S_SETUP: state <= S_ARB;
                    S_ARB: begin
                        if (drain_in) state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (credits == CREDITS_FULL) begin
                            state       <= S_DRAINED;
                            drained_out <= 1'b1;
                        end
                    end
                    S_DRAINED: begin
                        if (!drain_in) begin
                            state       <= S_ARB;
                            drained_out <= 1'b0;
                        end
                    end
                    default: state <= S_SETUP;
                endcase

                case ({grant_now, credit_return_in})
                    2'b10: credits <= credits - 1'b1;
                    2'b01: begin
                        if (credits == CREDITS_FULL) credit_overflow_out <= 1'b1;
                        else                         credits <= credits + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign credits_out = credits;

endmodule

// File: tb/tb_cache_request_credit_scheduler.sv
// Directed plus randomized bench for cache_request_credit_scheduler.
// Expected values come from a behavioural model of the scheduling rules.
module tb_cache_request_credit_scheduler;

    localparam int NR = 2;
    localparam int NC = 16;

    localparam int P_SETUP   = 0;
    localparam int P_ARB     = 1;
    localparam int P_DRAIN   = 2;
    localparam int P_DRAINED = 3;

    logic          ap_clk = 1'b0;
    logic          areset = 1'b0;
    logic [NR-1:0] req    = '0;
    logic          setup  = 1'b0;
    logic          ret    = 1'b0;
    logic          drain  = 1'b0;
    logic [NR-1:0] grant;
    logic [4:0]    credits;
    logic          drained;
    logic          overflow;

    int tests_run = 0;
    int tests_failed = 0;

    int          m_phase;
    int          m_credits;
    int          m_ptr;
    logic [NR-1:0] m_grant;
    bit          m_overflow;

    cache_request_credit_scheduler #(
        .NUM_MEMORY_REQUESTOR (NR),
        .NUM_CREDITS          (NC)
    ) dut (
        .ap_clk               (ap_clk),
        .areset               (areset),
        .arbiter_request_in   (req),
        .fifo_setup_signal_in (setup),
        .credit_return_in     (ret),
        .drain_in             (drain),
        .arbiter_grant_out    (grant),
        .credits_out          (credits),
        .drained_out          (drained),
        .credit_overflow_out  (overflow)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase    = P_SETUP;
        m_credits  = NC;
        m_ptr      = 0;
        m_grant    = '0;
        m_overflow = 1'b0;
    endfunction

    // One clock edge of the scheduling rules, using the inputs the DUT sampled.
    function automatic void model_edge();
        bit granted = 1'b0;
        int ret_v   = ret ? 1 : 0;
        m_grant = '0;
        if (setup) begin
            m_phase   = P_SETUP;
            m_credits = NC;
        end else begin
            case (m_phase)
                P_SETUP: m_phase = P_ARB;
                P_ARB: begin
                    if (drain) m_phase = P_DRAIN;
                    else if (req != 0 && m_credits + ret_v > 0) begin
                        for (int k = 0; k < NR; k++) begin
                            int i = (m_ptr + k) % NR;
                            if (!granted && req[i]) begin
                                granted    = 1'b1;
                                m_grant[i] = 1'b1;
                                m_ptr      = (i + 1) % NR;
                            end
                        end
                    end
                end
                P_DRAIN:   if (m_credits == NC) m_phase = P_DRAINED;
                default:   if (!drain) m_phase = P_ARB;
            endcase
            if (granted && !ret) m_credits--;
            else if (ret && !granted) begin
                if (m_credits == NC) m_overflow = 1'b1;
                else m_credits++;
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_grant"},    32'(grant),    32'(m_grant));
        check({tag, "_credits"},  32'(credits),  32'(m_credits));
        check({tag, "_drained"},  32'(drained),  32'(m_phase == P_DRAINED));
        check({tag, "_overflow"}, 32'(overflow), 32'(m_overflow));
    endtask

    task automatic step(input string tag);
        @(posedge ap_clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin
        int drain_hold = 0;

        // Reset state
        req   = 2'b11;
        setup = 1'b1;
        #1 areset = 1'b1;
        model_reset();
        #1;
        check("rst_grant",    32'(grant),    0);
        check("rst_credits",  32'(credits),  16);
        check("rst_drained",  32'(drained),  0);
        check("rst_overflow", 32'(overflow), 0);
        @(negedge ap_clk);
        areset = 1'b0;

        // 1. setup held for 5 cycles: no grants
        for (int i = 0; i < 5; i++) begin
            step("t1_setup");
            check("t1_no_grant", 32'(grant), 0);
        end
        setup = 1'b0;
        step("t1_enter_arb");
        check("t1_enter_grant",   32'(grant),   0);
        check("t1_enter_credits", 32'(credits), 16);

        // 2. both requesting, no returns: 16 alternating grants then starvation
        for (int i = 0; i < 16; i++) begin
            step("t2_burst");
            check("t2_alt_grant", 32'(grant),   (i % 2 == 0) ? 32'h1 : 32'h2);
            check("t2_credits",   32'(credits), 32'(15 - i));
        end
        for (int i = 0; i < 2; i++) begin
            step("t2_empty");
            check("t2_empty_grant",   32'(grant),   0);
            check("t2_empty_credits", 32'(credits), 0);
        end

        // 3. zero credits, simultaneous return funds a grant
        req = 2'b10;
        ret = 1'b1;
        step("t3_ret_grant");
        check("t3_grant",   32'(grant),   32'h2);
        check("t3_credits", 32'(credits), 0);
        req = 2'b00;
        ret = 1'b0;
        step("t3_idle");

        // Bring outstanding count down to 5
        ret = 1'b1;
        for (int i = 0; i < 11; i++) step("t4_refill");
        check("t4_pre_credits", 32'(credits), 11);

        // 4. drain with 5 outstanding
        ret   = 1'b0;
        req   = 2'b11;
        drain = 1'b1;
        step("t4_drain_start");
        check("t4_drain_no_grant", 32'(grant), 0);
        for (int k = 0; k < 5; k++) begin
            ret = 1'b1;
            step("t4_return");
            check("t4_ret_no_grant", 32'(grant),   0);
            check("t4_ret_drained",  32'(drained), 0);
            ret = 1'b0;
            step("t4_gap");
            check("t4_gap_drained", 32'(drained), (k == 4) ? 1 : 0);
        end
        check("t4_full_credits", 32'(credits), 16);
        drain = 1'b0;
        step("t4_release");
        check("t4_release_grant", 32'(grant), 0);
        step("t4_resume");
        check("t4_resume_grant",   32'(grant),   32'h1);
        check("t4_resume_credits", 32'(credits), 15);

        // 5. return while full sets sticky overflow
        req = 2'b00;
        ret = 1'b1;
        step("t5_fill");
        check("t5_fill_overflow", 32'(overflow), 0);
        step("t5_over");
        check("t5_overflow", 32'(overflow), 1);
        check("t5_credits",  32'(credits),  16);
        ret = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("t5_sticky");
            check("t5_sticky_overflow", 32'(overflow), 1);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            if (drain_hold > 0) drain_hold--;
            else if ($urandom_range(0, 19) == 0) drain_hold = int'($urandom_range(5, 30));
            drain = (drain_hold > 0);
            req   = NR'($urandom_range(0, 3));
            ret   = (m_credits < NC) && ($urandom_range(0, 2) != 0);
            setup = ($urandom_range(0, 63) == 0);
            step("rnd");
        end
        setup = 1'b0;
        drain = 1'b0;
        ret   = 1'b0;
        req   = 2'b00;

        // 6. reset mid-traffic with a grant pending
        #1 areset = 1'b1;
        model_reset();
        #1 areset = 1'b0;
        req = 2'b11;
        step("t6_enter");
        for (int i = 0; i < 9; i++) step("t6_traffic");
        check("t6_pre_credits", 32'(credits), 7);
        check("t6_pre_grant",   32'(grant != 0), 1);
        #1 areset = 1'b1;
        model_reset();
        #1;
        check("t6_rst_grant",    32'(grant),    0);
        check("t6_rst_credits",  32'(credits),  16);
        check("t6_rst_overflow", 32'(overflow), 0);
        #1 areset = 1'b0;
        step("t6_reenter");
        check("t6_reenter_grant", 32'(grant), 0);
        step("t6_first");
        check("t6_first_grant",   32'(grant),   32'h1);
        check("t6_first_credits", 32'(credits), 15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
